// File: rtl/ppu_pkg.sv
// PPU front-end shared definitions: register indices, CTRL/MASK/STATUS
// bit positions and the VRAM address step helper.
package ppu_pkg;

    localparam logic [2:0] PPU_CTRL    = 3'd0;
    localparam logic [2:0] PPU_MASK    = 3'd1;
    localparam logic [2:0] PPU_STATUS  = 3'd2;
    localparam logic [2:0] PPU_OAMADDR = 3'd3;
    localparam logic [2:0] PPU_OAMDATA = 3'd4;
    localparam logic [2:0] PPU_SCROLL  = 3'd5;
    localparam logic [2:0] PPU_ADDR    = 3'd6;
    localparam logic [2:0] PPU_DATA    = 3'd7;

    localparam int NMI_EN   = 7;
    localparam int INC32    = 2;
    localparam int SHOW_BG  = 3;
    localparam int SHOW_SPR = 4;

    localparam int ST_VBLANK   = 7;
    localparam int ST_SPR0_HIT = 6;
    localparam int ST_SPR_OVF  = 5;

    function automatic logic [13:0] vaddr_step(
        input logic [13:0] addr,
        input logic        inc32
    );
        return addr + (inc32 ? 14'd32 : 14'd1);
    endfunction

endpackage

// File: rtl/ppu_dot_counter.sv
// Dot/line/frame counters, including the short pre-render line
// taken on odd frames while rendering is enabled.
module ppu_dot_counter #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int ODD_FRAME_SKIP  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       rendering_enabled,
    output logic [8:0] o_dot,
    output logic [8:0] o_line,
    output logic       o_frame_odd
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] PRE_LINE  = 9'(LINES_PER_FRAME - 1);

    logic [8:0] dot_n;
    logic [8:0] line_n;
    logic       odd_n;
    logic       skip;

    assign skip = (ODD_FRAME_SKIP != 0) && o_frame_odd && rendering_enabled
                  && (o_line == PRE_LINE) && (o_dot == SKIP_DOT);

    always_comb begin
        dot_n  = o_dot + 9'd1;
        line_n = o_line;
        odd_n  = o_frame_odd;
        if (skip) begin
            dot_n  = '0;
            line_n = '0;
            odd_n  = ~o_frame_odd;
        end else if (o_dot == LAST_DOT) begin
            dot_n = '0;
            if (o_line == PRE_LINE) begin
                line_n = '0;
                odd_n  = ~o_frame_odd;
            end else begin
                line_n = o_line + 9'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dot       <= '0;
            o_line      <= '0;
            o_frame_odd <= 1'b0;
        end else begin
            o_dot       <= dot_n;
            o_line      <= line_n;
            o_frame_odd <= odd_n;
        end
    end

endmodule

// File: rtl/ppu_timing.sv
// PPU front end: raster timing, CPU register file, vblank flag and NMI.
// Drives dot coordinates, syncs and scroll/VRAM address state downstream.
module ppu_timing
    import ppu_pkg::*;
#(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VISIBLE_DOTS    = 256,
    parameter int VISIBLE_LINES   = 240,
    parameter int VBLANK_LINE     = 241,
    parameter int HSYNC_START     = 280,
    parameter int HSYNC_LEN       = 25,
    parameter int VSYNC_START     = 244,
    parameter int VSYNC_LEN       = 3,
    parameter int ODD_FRAME_SKIP  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic [2:0]  i_rs,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_int_n,
    output logic [8:0]  o_dot,
    output logic [8:0]  o_line,
    output logic        o_visible,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_frame_odd,
    output logic [7:0]  o_ctrl,
    output logic [7:0]  o_mask,
    output logic [7:0]  o_scroll_x,
    output logic [7:0]  o_scroll_y,
    output logic [13:0] o_vaddr,
    output logic        o_vram_rd,
    output logic        o_vram_wr
);

    localparam logic [8:0] VIS_D    = 9'(VISIBLE_DOTS);
    localparam logic [8:0] VIS_L    = 9'(VISIBLE_LINES);
    localparam logic [8:0] VBL_L    = 9'(VBLANK_LINE);
    localparam logic [8:0] PRE_L    = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] HS_BEG   = 9'(HSYNC_START);
    localparam logic [8:0] HS_END   = 9'(HSYNC_START + HSYNC_LEN);
    localparam logic [8:0] VS_BEG   = 9'(VSYNC_START);
    localparam logic [8:0] VS_END   = 9'(VSYNC_START + VSYNC_LEN);

    logic       vblank;
    logic       w;
    logic [7:0] latch;
    logic       wr;
    logic       rd;
    logic       status_rd;
    logic       data_acc;
    logic       vbl_set;
    logic       vbl_clr;

    ppu_dot_counter #(
        .DOTS_PER_LINE  (DOTS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME),
        .ODD_FRAME_SKIP (ODD_FRAME_SKIP)
    ) u_dot_counter (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .rendering_enabled(o_mask[SHOW_BG] | o_mask[SHOW_SPR]),
        .o_dot            (o_dot),
        .o_line           (o_line),
        .o_frame_odd      (o_frame_odd)
    );

    assign wr        = i_cs & ~i_rw;
    assign rd        = i_cs & i_rw;
    assign status_rd = rd && (i_rs == PPU_STATUS);
    assign data_acc  = i_cs && (i_rs == PPU_DATA);
    assign vbl_set   = (o_line == VBL_L) && (o_dot == 9'd1);
    assign vbl_clr   = (o_line == PRE_L) && (o_dot == 9'd1);

    assign o_visible = (o_dot < VIS_D) && (o_line < VIS_L);
    assign o_h_sync  = !((o_dot >= HS_BEG) && (o_dot < HS_END));
    assign o_v_sync  = !((o_line >= VS_BEG) && (o_line < VS_END));
    assign o_int_n   = ~(vblank & o_ctrl[NMI_EN]);
    assign o_vram_wr = wr && (i_rs == PPU_DATA);
    assign o_vram_rd = rd && (i_rs == PPU_DATA);

    always_comb begin
        o_data = '0;
        if (rd) begin
            if (i_rs == PPU_STATUS)
                o_data = {vblank, 2'b00, latch[4:0]};
            else
                o_data = latch;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vblank     <= 1'b0;
            w          <= 1'b0;
            latch      <= '0;
            o_ctrl     <= '0;
            o_mask     <= '0;
            o_scroll_x <= '0;
            o_scroll_y <= '0;
            o_vaddr    <= '0;
        end else begin
            // A STATUS read on the set dot wins, suppressing vblank this frame.
            if (vbl_set && !status_rd)
                vblank <= 1'b1;
            else if (vbl_clr || status_rd)
                vblank <= 1'b0;

            if (status_rd)
                w <= 1'b0;

            if (wr) begin
                latch <= i_data;
                unique case (i_rs)
                    PPU_CTRL: o_ctrl <= i_data;
                    PPU_MASK: o_mask <= i_data;
                    PPU_SCROLL: begin
                        if (w) o_scroll_y <= i_data;
                        else   o_scroll_x <= i_data;
                        w <= ~w;
                    end
                    PPU_ADDR: begin
                        if (w) o_vaddr[7:0]  <= i_data;
                        else   o_vaddr[13:8] <= i_data[5:0];
                        w <= ~w;
                    end
                    default: ;
                endcase
            end

            if (data_acc)
                o_vaddr <= vaddr_step(o_vaddr, o_ctrl[INC32]);
        end
    end

endmodule
